fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/RISCV_PKG.sv | 16 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/RISCV_PKG.sv
// Shared types and constants for the instruction fetch path.
package RISCV_PKG;

   localparam int unsigned FETCH_DEPTH = 2;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] PC;
      logic [31:0] Instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry buffer of fetched {PC, Instr} pairs, decode side pops from the head.
module fetch_fifo
   import RISCV_PKG::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  fetch_entry_t             i_push_data,
   input  logic                     i_pop,
   output fetch_entry_t             o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Caller never pushes when full (credit scheme); pops on empty are ignored.
   assign w_push = i_push;
   assign w_pop  = i_pop && (r_count != '0);

   // Pointer and occupancy tracking; flush empties the buffer in one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are only observed while the slot is occupied.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: accepts PCs, issues memory requests, matches in-order
// responses to their PCs and buffers the results for decode.
module fetch_unit
   import RISCV_PKG::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] PC,
   input  logic        PCValid,
   output logic        PCReady,
   input  logic        Flush,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemGnt,
   input  logic        IMemRValid,
   input  logic [31:0] IMemRData,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_state_t  r_state;
   logic          r_imem_req;
   logic [31:0]   r_imem_addr;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop_cnt;
   logic [31:0]   r_pend [DEPTH];
   logic [AW-1:0] r_pend_wr;
   logic [AW-1:0] r_pend_rd;

   logic [CW-1:0] w_fifo_count;
   logic [CW-1:0] w_credits;
   logic [CW-1:0] w_inflight_next;
   logic          w_pc_fire;
   logic          w_grant;
   logic          w_resp;
   logic          w_drop;
   logic          w_fifo_push;
   logic          w_fifo_pop;
   fetch_entry_t  w_push_entry;
   fetch_entry_t  w_head;

   // Every accepted PC reserves one slot until it leaves the buffer, so the
   // buffer can never overflow.
   assign w_credits = CW'(DEPTH) - w_fifo_count - r_inflight;
   assign PCReady   = !Reset && (r_state == IDLE) && !Flush && (w_credits != '0);
   assign w_pc_fire = PCValid && PCReady;

   assign w_grant = (r_state == REQ) && IMemGnt;
   // Responses with nothing outstanding (e.g. stale after reset) are ignored.
   assign w_resp  = IMemRValid && (r_inflight != '0);
   assign w_drop  = w_resp && ((r_drop_cnt != '0) || Flush);
   assign w_fifo_push = w_resp && !w_drop;
   assign w_fifo_pop  = InstrValid && InstrReady;

   assign w_inflight_next = r_inflight + CW'(w_grant) - CW'(w_resp);

   // Pair the oldest outstanding PC with the returning data.
   always_comb begin
      w_push_entry       = '0;
      w_push_entry.PC    = r_pend[r_pend_rd];
      w_push_entry.Instr = IMemRData;
   end

   // Request FSM: hold address/request until granted or withdrawn by flush.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_imem_req  <= 1'b0;
         r_imem_addr <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pc_fire) begin
                  r_imem_addr <= PC;
                  r_imem_req  <= 1'b1;
                  r_state     <= REQ;
               end
            end
            REQ: begin
               if (IMemGnt || Flush) begin
                  r_imem_req <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_imem_req <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   // Outstanding-fetch accounting; on flush every fetch still outstanding
   // after this cycle (including a same-cycle grant) becomes a drop.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_pend_wr  <= '0;
         r_pend_rd  <= '0;
      end else begin
         r_inflight <= w_inflight_next;
         if (Flush) begin
            r_drop_cnt <= w_inflight_next;
         end else if (w_resp && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
         end
         if (w_grant) r_pend_wr <= r_pend_wr + AW'(1);
         if (w_resp)  r_pend_rd <= r_pend_rd + AW'(1);
      end
   end

   // Pending-PC storage, written with the granted address.
   always_ff @(posedge CLK) begin
      if (w_grant) r_pend[r_pend_wr] <= r_imem_addr;
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk       (CLK),
      .i_rst       (Reset),
      .i_flush     (Flush),
      .i_push      (w_fifo_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_fifo_pop),
      .o_head      (w_head),
      .o_count     (w_fifo_count)
   );

   assign IMemReq    = r_imem_req;
   assign IMemAddr   = r_imem_addr;
   assign InstrValid = (w_fifo_count != '0);
   assign Instr      = InstrValid ? w_head.Instr : '0;
   assign InstrPC    = InstrValid ? w_head.PC    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2): each task drives one scenario
// cycle by cycle and checks outputs 1ns after the rising edge.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] PC;
   logic        PCValid;
   logic        PCReady;
   logic        Flush;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemGnt;
   logic        IMemRValid;
   logic [31:0] IMemRData;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] Instr;
   logic [31:0] InstrPC;

   int n_vec  = 0;
   int n_miss = 0;

   fetch_unit #(.DEPTH(2)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .PC         (PC),
      .PCValid    (PCValid),
      .PCReady    (PCReady),
      .Flush      (Flush),
      .IMemReq    (IMemReq),
      .IMemAddr   (IMemAddr),
      .IMemGnt    (IMemGnt),
      .IMemRValid (IMemRValid),
      .IMemRData  (IMemRData),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .Instr      (Instr),
      .InstrPC    (InstrPC)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200us");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; PC = '0; PCValid = 1'b0; Flush = 1'b0; IMemGnt = 1'b0;
      IMemRValid = 1'b0; IMemRData = '0; InstrReady = 1'b0;
      #2;
      n_vec++; if (PCReady !== 1'b0) begin n_miss++; $display("FAIL rst_pcready: got %b want 0", PCReady); end
      n_vec++; if ({IMemReq, InstrValid, IMemAddr, Instr, InstrPC} !== '0) begin n_miss++;
         $display("FAIL rst_outputs: got req=%b iv=%b addr=%h instr=%h ipc=%h want all 0", IMemReq, InstrValid, IMemAddr, Instr, InstrPC); end
      tick(); tick();
      Reset = 1'b0; #1;
      n_vec++; if (PCReady !== 1'b1) begin n_miss++; $display("FAIL rst_release_pcready: got %b want 1", PCReady); end
   endtask

   task automatic test_single();
      PC = 32'h100; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      n_vec++; if ({IMemReq, IMemAddr} !== {1'b1, 32'h100}) begin n_miss++; $display("FAIL single_req: got req=%b addr=%h want 1/00000100", IMemReq, IMemAddr); end
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h00500093;
      n_vec++; if ({IMemReq, InstrValid} !== 2'b00) begin n_miss++; $display("FAIL single_n2: got req=%b iv=%b want 0/0", IMemReq, InstrValid); end
      tick();
      IMemRValid = 1'b0;
      n_vec++; if ({InstrValid, Instr, InstrPC} !== {1'b1, 32'h00500093, 32'h100}) begin n_miss++;
         $display("FAIL single_deliver: got iv=%b instr=%h pc=%h want 1/00500093/00000100", InstrValid, Instr, InstrPC); end
      InstrReady = 1'b1;
      tick();
      n_vec++; if (InstrValid !== 1'b0) begin n_miss++; $display("FAIL single_pop: got iv=%b want 0", InstrValid); end
      InstrReady = 1'b0;
   endtask

   task automatic test_backpressure();
      InstrReady = 1'b0; PC = 32'h0; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      n_vec++; if ({IMemReq, IMemAddr} !== {1'b1, 32'h0}) begin n_miss++; $display("FAIL bp_req0: got req=%b addr=%h want 1/00000000", IMemReq, IMemAddr); end
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hAAAA0000; PC = 32'h4; PCValid = 1'b1; #1;
      n_vec++; if (PCReady !== 1'b1) begin n_miss++; $display("FAIL bp_pcready2: got %b want 1", PCReady); end
      tick();
      IMemRValid = 1'b0; IMemGnt = 1'b1; PC = 32'h8; PCValid = 1'b1;
      n_vec++; if (IMemAddr !== 32'h4) begin n_miss++; $display("FAIL bp_addr4: got %h want 00000004", IMemAddr); end
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hBBBB0004; #1;
      n_vec++; if (PCReady !== 1'b0) begin n_miss++; $display("FAIL bp_nocredit: got %b want 0", PCReady); end
      tick();
      IMemRValid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_vec++; if ({PCReady, IMemReq, InstrValid, Instr, InstrPC} !== {3'b001, 32'hAAAA0000, 32'h0}) begin n_miss++;
            $display("FAIL bp_hold%0d: got rdy=%b req=%b iv=%b instr=%h pc=%h want 0/0/1/aaaa0000/00000000", i, PCReady, IMemReq, InstrValid, Instr, InstrPC); end
         if (i == 1) InstrReady = 1'b1;
         tick();
      end
      n_vec++; if ({InstrValid, Instr, InstrPC, PCReady} !== {1'b1, 32'hBBBB0004, 32'h4, 1'b1}) begin n_miss++;
         $display("FAIL bp_second: got iv=%b instr=%h pc=%h rdy=%b want 1/bbbb0004/00000004/1", InstrValid, Instr, InstrPC, PCReady); end
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      n_vec++; if ({IMemReq, IMemAddr, InstrValid} !== {1'b1, 32'h8, 1'b0}) begin n_miss++;
         $display("FAIL bp_third_req: got req=%b addr=%h iv=%b want 1/00000008/0", IMemReq, IMemAddr, InstrValid); end
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hCCCC0008;
      tick();
      IMemRValid = 1'b0;
      n_vec++; if ({InstrValid, Instr, InstrPC} !== {1'b1, 32'hCCCC0008, 32'h8}) begin n_miss++;
         $display("FAIL bp_third: got iv=%b instr=%h pc=%h want 1/cccc0008/00000008", InstrValid, Instr, InstrPC); end
      tick();
   endtask

   task automatic test_grant_stall();
      InstrReady = 1'b0; PC = 32'h20; PCValid = 1'b1;
      tick();
      PCValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         IMemGnt = (i == 3); #1;
         n_vec++; if ({IMemReq, IMemAddr, PCReady} !== {1'b1, 32'h20, 1'b0}) begin n_miss++;
            $display("FAIL stall_c%0d: got req=%b addr=%h rdy=%b want 1/00000020/0", i, IMemReq, IMemAddr, PCReady); end
         tick();
      end
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0BADF00D;
      n_vec++; if (IMemReq !== 1'b0) begin n_miss++; $display("FAIL stall_release: got req=%b want 0", IMemReq); end
      tick();
      IMemRValid = 1'b0; InstrReady = 1'b1;
      n_vec++; if ({InstrValid, Instr, InstrPC} !== {1'b1, 32'h0BADF00D, 32'h20}) begin n_miss++;
         $display("FAIL stall_deliver: got iv=%b instr=%h pc=%h want 1/0badf00d/00000020", InstrValid, Instr, InstrPC); end
      tick();
   endtask

   task automatic test_flush_inflight();
      InstrReady = 1'b1; PC = 32'h40; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; PC = 32'h44; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      n_vec++; if (IMemAddr !== 32'h44) begin n_miss++; $display("FAIL fl2_addr: got %h want 00000044", IMemAddr); end
      tick();
      IMemGnt = 1'b0; Flush = 1'b1; #1;
      n_vec++; if (PCReady !== 1'b0) begin n_miss++; $display("FAIL fl2_pcready: got %b want 0", PCReady); end
      tick();
      Flush = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h11111111;
      tick();
      IMemRData = 32'h22222222;
      n_vec++; if (InstrValid !== 1'b0) begin n_miss++; $display("FAIL fl2_drop1: got iv=%b want 0", InstrValid); end
      tick();
      IMemRValid = 1'b0; #1;
      n_vec++; if ({InstrValid, PCReady} !== 2'b01) begin n_miss++; $display("FAIL fl2_drop2: got iv=%b rdy=%b want 0/1", InstrValid, PCReady); end
      PC = 32'h200; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h00200213;
      tick();
      IMemRValid = 1'b0;
      n_vec++; if ({InstrValid, Instr, InstrPC} !== {1'b1, 32'h00200213, 32'h200}) begin n_miss++;
         $display("FAIL fl2_next: got iv=%b instr=%h pc=%h want 1/00200213/00000200", InstrValid, Instr, InstrPC); end
      tick();
   endtask

   task automatic test_flush_req();
      InstrReady = 1'b0; PC = 32'h300; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b0; Flush = 1'b1; #1;
      n_vec++; if ({IMemReq, PCReady} !== 2'b10) begin n_miss++; $display("FAIL flreq_n: got req=%b rdy=%b want 1/0", IMemReq, PCReady); end
      tick();
      Flush = 1'b0; #1;
      n_vec++; if ({IMemReq, PCReady} !== 2'b01) begin n_miss++; $display("FAIL flreq_withdrawn: got req=%b rdy=%b want 0/1", IMemReq, PCReady); end
      Flush = 1'b1; #1;
      n_vec++; if (PCReady !== 1'b0) begin n_miss++; $display("FAIL flreq_idle_flush: got rdy=%b want 0", PCReady); end
      Flush = 1'b0; PC = 32'h304; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; #1;
      n_vec++; if (PCReady !== 1'b1) begin n_miss++; $display("FAIL flreq_credit: got rdy=%b want 1", PCReady); end
      PC = 32'h308; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000D304; #1;
      n_vec++; if (PCReady !== 1'b0) begin n_miss++; $display("FAIL flreq_full: got rdy=%b want 0", PCReady); end
      tick();
      IMemRData = 32'h0000D308;
      n_vec++; if ({Instr, InstrPC} !== {32'h0000D304, 32'h304}) begin n_miss++; $display("FAIL flreq_first: got instr=%h pc=%h want 0000d304/00000304", Instr, InstrPC); end
      tick();
      IMemRValid = 1'b0;
      n_vec++; if ({Instr, InstrPC} !== {32'h0000D304, 32'h304}) begin n_miss++; $display("FAIL flreq_held: got instr=%h pc=%h want 0000d304/00000304", Instr, InstrPC); end
      InstrReady = 1'b1;
      tick();
      n_vec++; if ({InstrValid, Instr, InstrPC} !== {1'b1, 32'h0000D308, 32'h308}) begin n_miss++;
         $display("FAIL flreq_second: got iv=%b instr=%h pc=%h want 1/0000d308/00000308", InstrValid, Instr, InstrPC); end
      tick();
      n_vec++; if (InstrValid !== 1'b0) begin n_miss++; $display("FAIL flreq_empty: got iv=%b want 0", InstrValid); end
   endtask

   task automatic test_flush_fifo();
      InstrReady = 1'b0; PC = 32'h500; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000A500; PC = 32'h504; PCValid = 1'b1;
      tick();
      IMemRValid = 1'b0; PCValid = 1'b0; IMemGnt = 1'b1;
      n_vec++; if ({InstrValid, InstrPC} !== {1'b1, 32'h500}) begin n_miss++; $display("FAIL flfifo_buffered: got iv=%b pc=%h want 1/00000500", InstrValid, InstrPC); end
      tick();
      IMemGnt = 1'b0; Flush = 1'b1; IMemRValid = 1'b1; IMemRData = 32'h0000B504;
      tick();
      Flush = 1'b0; IMemRValid = 1'b0; #1;
      n_vec++; if ({InstrValid, PCReady} !== 2'b01) begin n_miss++; $display("FAIL flfifo_emptied: got iv=%b rdy=%b want 0/1", InstrValid, PCReady); end
      PC = 32'h600; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000C600;
      tick();
      IMemRValid = 1'b0;
      n_vec++; if ({InstrValid, Instr, InstrPC} !== {1'b1, 32'h0000C600, 32'h600}) begin n_miss++;
         $display("FAIL flfifo_next: got iv=%b instr=%h pc=%h want 1/0000c600/00000600", InstrValid, Instr, InstrPC); end
      InstrReady = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      InstrReady = 1'b0; PC = 32'h700; PCValid = 1'b1;
      tick();
      PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000E700; PC = 32'h704; PCValid = 1'b1;
      tick();
      IMemRValid = 1'b0; PCValid = 1'b0; IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000E704;
      tick();
      IMemRValid = 1'b0;
      n_vec++; if ({InstrValid, PCReady} !== 2'b10) begin n_miss++; $display("FAIL rmid_full: got iv=%b rdy=%b want 1/0", InstrValid, PCReady); end
      Reset = 1'b1; #1;
      n_vec++; if ({InstrValid, PCReady, IMemReq} !== 3'b000) begin n_miss++; $display("FAIL rmid_async: got iv=%b rdy=%b req=%b want 0/0/0", InstrValid, PCReady, IMemReq); end
      tick();
      Reset = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hDEADBEEF; #1;
      n_vec++; if (PCReady !== 1'b1) begin n_miss++; $display("FAIL rmid_release: got rdy=%b want 1", PCReady); end
      tick();
      IMemRValid = 1'b0;
      n_vec++; if ({InstrValid, PCReady} !== 2'b01) begin n_miss++; $display("FAIL rmid_stray: got iv=%b rdy=%b want 0/1", InstrValid, PCReady); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_grant_stall();
      test_flush_inflight();
      test_flush_req();
      test_flush_fifo();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
